// File: rtl/exu_store_queue.sv
// In-order store queue between EX and the memory write port: aligns store data and byte masks,
// holds MMIO stores alone in the queue, and flags loads that overlap a pending store.
module exu_store_queue #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned DEPTH    = 4,
  parameter logic [3:0]  MMIO_TAG = 4'hA
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [XLEN-1:0]            req_addr,
  input  logic [XLEN-1:0]            req_data,
  input  logic [1:0]                 req_size,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [XLEN-1:0]            mem_addr,
  output logic [XLEN-1:0]            mem_data,
  output logic [XLEN/8-1:0]          mem_mask,
  output logic                       mem_mmio,
  input  logic [XLEN-1:0]            chk_addr,
  input  logic [1:0]                 chk_size,
  output logic                       chk_hit,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       err
);

  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OFFW = $clog2(NB);
  localparam int unsigned PTRW = $clog2(DEPTH);
  localparam int unsigned CNTW = PTRW + 1;

  function automatic logic [NB-1:0] lane_mask(input logic [OFFW-1:0] off, input logic [1:0] size);
    logic [NB-1:0] m;
    int unsigned   o;
    int unsigned   n;
    o = 32'(off);
    n = 32'd1 << size;
    m = '0;
    for (int unsigned b = 0; b < NB; b++) m[b] = (b >= o) && (b < o + n);
    return m;
  endfunction

  logic [XLEN-1:0] ent_addr_q [DEPTH];
  logic [XLEN-1:0] ent_data_q [DEPTH];
  logic [NB-1:0]   ent_mask_q [DEPTH];
  logic            ent_mmio_q [DEPTH];

  logic [PTRW-1:0] wptr_q, rptr_q;
  logic [CNTW-1:0] count_q, count_d;
  logic            err_q;

  logic            full, accept, push, pop, mmio_pending, req_is_mmio, req_bad;
  logic [XLEN-1:0] req_aaddr, req_wdata, req_low, chk_aaddr;
  logic [NB-1:0]   req_mask, chk_mask;
  logic [DEPTH-1:0] ent_vld;
  int unsigned     req_off, req_nb;

  always_comb begin
    req_off   = 32'(req_addr[OFFW-1:0]);
    req_nb    = 32'd1 << req_size;
    req_bad   = ((req_off & (req_nb - 1)) != 0) || (req_size == 2'd3 && XLEN == 32);
    req_mask  = lane_mask(req_addr[OFFW-1:0], req_size);
    req_low   = '0;
    for (int unsigned b = 0; b < NB; b++) if (b < req_nb) req_low[8*b +: 8] = 8'hFF;
    req_wdata = (req_data & req_low) << (8 * req_off);
    req_aaddr = {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
    req_is_mmio = (req_addr[31:28] == MMIO_TAG);
  end

  // Entry i is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    ent_vld      = '0;
    mmio_pending = 1'b0;
    chk_hit      = 1'b0;
    chk_aaddr    = {chk_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
    chk_mask     = lane_mask(chk_addr[OFFW-1:0], chk_size);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_vld[i] = ({1'b0, PTRW'(i) - rptr_q} < count_q);
      if (ent_vld[i] && ent_mmio_q[i]) mmio_pending = 1'b1;
      if (ent_vld[i] && ent_addr_q[i] == chk_aaddr && (ent_mask_q[i] & chk_mask) != '0)
        chk_hit = 1'b1;
    end
  end

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNTW'(DEPTH));
  assign req_ready = !full && !mmio_pending && !(req_is_mmio && !empty);
  assign accept    = req_valid && req_ready;
  assign push      = accept && !req_bad;
  assign mem_valid = !empty;
  assign pop       = mem_valid && mem_ready;

  assign mem_addr  = ent_addr_q[rptr_q];
  assign mem_data  = ent_data_q[rptr_q];
  assign mem_mask  = ent_mask_q[rptr_q];
  assign mem_mmio  = mem_valid && ent_mmio_q[rptr_q];
  assign count     = count_q;
  assign err       = err_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + PTRW'(1);
      if (pop)  rptr_q <= rptr_q + PTRW'(1);
      count_q <= count_d;
      err_q   <= accept && req_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      ent_addr_q[wptr_q] <= req_aaddr;
      ent_data_q[wptr_q] <= req_wdata;
      ent_mask_q[wptr_q] <= req_mask;
      ent_mmio_q[wptr_q] <= req_is_mmio;
    end
  end

endmodule

// File: tb/tb_exu_store_queue.sv
// Directed bench for exu_store_queue (XLEN=64, DEPTH=4): alignment, fill/drain order, MMIO
// serialisation, error pulses, load-overlap check and reset during drain.
module tb_exu_store_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [63:0] req_addr, req_data;
  logic [1:0]  req_size;
  logic        mem_valid, mem_ready;
  logic [63:0] mem_addr, mem_data;
  logic [7:0]  mem_mask;
  logic        mem_mmio;
  logic [63:0] chk_addr;
  logic [1:0]  chk_size;
  logic        chk_hit;
  logic [2:0]  count;
  logic        empty, err;

  int n_chk  = 0;
  int n_fail = 0;

  exu_store_queue #(.XLEN(64), .DEPTH(4), .MMIO_TAG(4'hA)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_data(req_data), .req_size(req_size),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_mask(mem_mask), .mem_mmio(mem_mmio),
    .chk_addr(chk_addr), .chk_size(chk_size), .chk_hit(chk_hit),
    .count(count), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [63:0] a, input logic [63:0] d, input logic [1:0] s);
    req_valid = v;
    req_addr  = a;
    req_data  = d;
    req_size  = s;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b0; chk_addr = 64'h0; chk_size = 2'd0;
    put(1'b0, 64'h0, 64'h0, 2'd0);
    step(); step();
    rst = 1'b0;
    #1;
    n_chk++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count got %0d want 0", count); end
    n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty got %b want 1", empty); end
    n_chk++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mem_valid got %b want 0", mem_valid); end
    n_chk++; if (mem_mmio !== 1'b0) begin n_fail++; $display("FAIL rst_mem_mmio got %b want 0", mem_mmio); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b want 0", err); end
    n_chk++; if (chk_hit !== 1'b0) begin n_fail++; $display("FAIL rst_chk_hit got %b want 0", chk_hit); end
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
  endtask

  task automatic test_align();
    put(1'b1, 64'h80000005, 64'hFFFF_FFFF_FFFF_FFAB, 2'd0);
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL sb_ready got %b want 1", req_ready); end
    n_chk++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL sb_no_bypass got %b want 0", mem_valid); end
    step();
    put(1'b0, 64'h0, 64'h0, 2'd0);
    n_chk++; if (mem_valid !== 1'b1) begin n_fail++; $display("FAIL sb_valid got %b want 1", mem_valid); end
    n_chk++; if (mem_addr !== 64'h80000000) begin n_fail++; $display("FAIL sb_addr got %h want 80000000", mem_addr); end
    n_chk++; if (mem_mask !== 8'b00100000) begin n_fail++; $display("FAIL sb_mask got %b want 00100000", mem_mask); end
    n_chk++; if (mem_data !== 64'h0000AB0000000000) begin n_fail++; $display("FAIL sb_data got %h want 0000ab0000000000", mem_data); end
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL sb_drained got %b want 1", empty); end
  endtask

  task automatic test_full();
    logic [63:0] exp_d;
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put(1'b1, 64'h80000100 + 64'(8*i), 64'(i + 1), 2'd3);
      step();
    end
    put(1'b1, 64'h80000120, 64'd5, 2'd3);
    n_chk++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count got %0d want 4", count); end
    n_chk++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b want 0", req_ready); end
    mem_ready = 1'b1;
    #1;
    n_chk++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL full_pop_ready got %b want 0", req_ready); end
    n_chk++; if (mem_data !== 64'd1) begin n_fail++; $display("FAIL full_head0 got %h want 1", mem_data); end
    step();
    n_chk++; if (count !== 3'd3) begin n_fail++; $display("FAIL full_after_pop got %0d want 3", count); end
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL full_freed_ready got %b want 1", req_ready); end
    step();
    put(1'b0, 64'h0, 64'h0, 2'd0);
    n_chk++; if (count !== 3'd3) begin n_fail++; $display("FAIL full_pushpop_count got %0d want 3", count); end
    for (int k = 3; k <= 5; k++) begin
      exp_d = 64'(k);
      n_chk++; if (mem_valid !== 1'b1 || mem_data !== exp_d) begin n_fail++; $display("FAIL full_order got v=%b d=%h want v=1 d=%h", mem_valid, mem_data, exp_d); end
      step();
    end
    mem_ready = 1'b0;
    n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL full_drained got %b want 1", empty); end
  endtask

  task automatic test_mmio();
    mem_ready = 1'b0;
    put(1'b1, 64'h80000200, 64'h11, 2'd3); step();
    put(1'b1, 64'h80000208, 64'h22, 2'd3); step();
    put(1'b1, 64'hA0000000, 64'h1122334455667788, 2'd3);
    n_chk++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL mmio_wait_ready got %b want 0", req_ready); end
    mem_ready = 1'b1;
    step();
    n_chk++; if (req_ready !== 1'b0 || count !== 3'd1) begin n_fail++; $display("FAIL mmio_wait1 got rdy=%b cnt=%0d want rdy=0 cnt=1", req_ready, count); end
    step();
    mem_ready = 1'b0;
    #1;
    n_chk++; if (req_ready !== 1'b1 || count !== 3'd0) begin n_fail++; $display("FAIL mmio_enter got rdy=%b cnt=%0d want rdy=1 cnt=0", req_ready, count); end
    step();
    put(1'b1, 64'h80000040, 64'h5A, 2'd0);
    n_chk++; if (mem_mmio !== 1'b1) begin n_fail++; $display("FAIL mmio_flag got %b want 1", mem_mmio); end
    n_chk++; if (mem_addr !== 64'hA0000000 || mem_mask !== 8'hFF) begin n_fail++; $display("FAIL mmio_head got a=%h m=%h want a=a0000000 m=ff", mem_addr, mem_mask); end
    n_chk++; if (mem_data !== 64'h1122334455667788) begin n_fail++; $display("FAIL mmio_data got %h want 1122334455667788", mem_data); end
    n_chk++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL mmio_block got %b want 0", req_ready); end
    step();
    n_chk++; if (count !== 3'd1 || req_ready !== 1'b0) begin n_fail++; $display("FAIL mmio_hold got cnt=%0d rdy=%b want cnt=1 rdy=0", count, req_ready); end
    mem_ready = 1'b1;
    #1;
    n_chk++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL mmio_ready_indep got %b want 0", req_ready); end
    step();
    n_chk++; if (count !== 3'd0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL mmio_popped got cnt=%0d rdy=%b want cnt=0 rdy=1", count, req_ready); end
    step();
    put(1'b0, 64'h0, 64'h0, 2'd0);
    mem_ready = 1'b0;
    #1;
    n_chk++; if (mem_mmio !== 1'b0 || mem_mask !== 8'h01 || mem_data !== 64'h5A || count !== 3'd1) begin n_fail++; $display("FAIL mmio_follow got mmio=%b m=%h d=%h cnt=%0d want mmio=0 m=01 d=5a cnt=1", mem_mmio, mem_mask, mem_data, count); end
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
  endtask

  task automatic test_misaligned();
    put(1'b1, 64'h80000002, 64'hDEADBEEF, 2'd2);
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mis_ready got %b want 1", req_ready); end
    step();
    put(1'b0, 64'h0, 64'h0, 2'd0);
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL mis_err got %b want 1", err); end
    n_chk++; if (count !== 3'd0 || mem_valid !== 1'b0) begin n_fail++; $display("FAIL mis_noenq got cnt=%0d v=%b want cnt=0 v=0", count, mem_valid); end
    step();
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL mis_err_pulse got %b want 0", err); end
  endtask

  task automatic test_chk();
    mem_ready = 1'b0;
    chk_addr = 64'h80000011; chk_size = 2'd0;
    put(1'b1, 64'h80000010, 64'hBEEF, 2'd1);
    n_chk++; if (chk_hit !== 1'b0) begin n_fail++; $display("FAIL chk_same_cycle got %b want 0", chk_hit); end
    step();
    put(1'b0, 64'h0, 64'h0, 2'd0);
    n_chk++; if (mem_mask !== 8'b00000011) begin n_fail++; $display("FAIL chk_sh_mask got %b want 00000011", mem_mask); end
    n_chk++; if (chk_hit !== 1'b1) begin n_fail++; $display("FAIL chk_hit_11 got %b want 1", chk_hit); end
    chk_addr = 64'h80000012; #1;
    n_chk++; if (chk_hit !== 1'b0) begin n_fail++; $display("FAIL chk_hit_12 got %b want 0", chk_hit); end
    chk_addr = 64'h80000018; chk_size = 2'd3; #1;
    n_chk++; if (chk_hit !== 1'b0) begin n_fail++; $display("FAIL chk_other_word got %b want 0", chk_hit); end
    chk_addr = 64'h80000011; chk_size = 2'd0; mem_ready = 1'b1; #1;
    n_chk++; if (chk_hit !== 1'b1) begin n_fail++; $display("FAIL chk_popping got %b want 1", chk_hit); end
    step();
    mem_ready = 1'b0;
    n_chk++; if (chk_hit !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL chk_after_pop got hit=%b e=%b want hit=0 e=1", chk_hit, empty); end
  endtask

  task automatic test_back_to_back();
    mem_ready = 1'b1;
    put(1'b1, 64'h80000300, 64'hA1, 2'd3); step();
    put(1'b1, 64'h80000308, 64'hB2, 2'd3);
    n_chk++; if (count !== 3'd1 || mem_data !== 64'hA1) begin n_fail++; $display("FAIL b2b_0 got cnt=%0d d=%h want cnt=1 d=a1", count, mem_data); end
    step();
    put(1'b1, 64'h80000310, 64'hC3, 2'd3);
    n_chk++; if (count !== 3'd1 || mem_data !== 64'hB2) begin n_fail++; $display("FAIL b2b_1 got cnt=%0d d=%h want cnt=1 d=b2", count, mem_data); end
    step();
    put(1'b1, 64'h80000301, 64'h0, 2'd1);
    n_chk++; if (count !== 3'd1 || mem_data !== 64'hC3 || err !== 1'b0) begin n_fail++; $display("FAIL b2b_2 got cnt=%0d d=%h err=%b want cnt=1 d=c3 err=0", count, mem_data, err); end
    step();
    n_chk++; if (err !== 1'b1 || count !== 3'd0) begin n_fail++; $display("FAIL b2b_err1 got err=%b cnt=%0d want err=1 cnt=0", err, count); end
    step();
    put(1'b0, 64'h0, 64'h0, 2'd0);
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL b2b_err2 got %b want 1", err); end
    step();
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL b2b_err_end got %b want 0", err); end
    mem_ready = 1'b0;
  endtask

  task automatic test_rst_mid_drain();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put(1'b1, 64'h80000400 + 64'(8*i), 64'(16 + i), 2'd3);
      step();
    end
    put(1'b0, 64'h0, 64'h0, 2'd0);
    n_chk++; if (count !== 3'd3 || mem_valid !== 1'b1) begin n_fail++; $display("FAIL rd_pre got cnt=%0d v=%b want cnt=3 v=1", count, mem_valid); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_chk++; if (count !== 3'd0 || empty !== 1'b1 || mem_valid !== 1'b0) begin n_fail++; $display("FAIL rd_post got cnt=%0d e=%b v=%b want cnt=0 e=1 v=0", count, empty, mem_valid); end
    step();
    n_chk++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL rd_quiet got %b want 0", mem_valid); end
    put(1'b1, 64'h80000001, 64'h77, 2'd0);
    step();
    put(1'b0, 64'h0, 64'h0, 2'd0);
    n_chk++; if (mem_valid !== 1'b1 || mem_data !== 64'h7700 || mem_mask !== 8'h02 || mem_addr !== 64'h80000000) begin n_fail++; $display("FAIL rd_new got v=%b d=%h m=%h a=%h want v=1 d=7700 m=02 a=80000000", mem_valid, mem_data, mem_mask, mem_addr); end
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rd_drained got %b want 1", empty); end
  endtask

  initial begin
    test_reset();
    test_align();
    test_full();
    test_mmio();
    test_misaligned();
    test_chk();
    test_back_to_back();
    test_rst_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/exu_store_queue.md
# exu_store_queue

Parametrised store queue for the EX stage, replacing the single-cycle, unbuffered store handshake that stalls EX on every memory store. It accepts store requests from EX, aligns data and generates byte masks per access size, and buffers up to DEPTH stores in order. It drains them to the memory write port over a valid/ready handshake. It also serialises MMIO stores and reports load-vs-pending-store overlap so LSU can stall dependent loads.

## Interface
- XLEN, 64, data/address width; 32 or 64.
- DEPTH, 4, queue entries; power of two, ≥2.
- MMIO_TAG, 4'hA, value of addr[31:28] marking a device store.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  EX presents a store.
- req_ready  out  1  queue accepts the store this cycle.
- req_addr  in  XLEN  byte address.
- req_data  in  XLEN  store data, right-aligned.
- req_size  in  2  0=byte, 1=half, 2=word, 3=double (illegal when XLEN=32).
- mem_valid  out  1  head entry presented to memory.
- mem_ready  in  1  memory accepts the head.
- mem_addr  out  XLEN  address with low log2(XLEN/8) bits cleared.
- mem_data  out  XLEN  lane-shifted data.
- mem_mask  out  XLEN/8  byte strobe.
- mem_mmio  out  1  head is a device store.
- chk_addr  in  XLEN  load address from EX/LS.
- chk_size  in  2  load size, same encoding as req_size.
- chk_hit  out  1  combinational; load overlaps a pending store.
- count  out  log2(DEPTH)+1  occupied entries.
- empty  out  1  count==0.
- err  out  1  one-cycle pulse: misaligned or illegal-size store dropped.

## Operation
- Handshake: a request is accepted when req_valid && req_ready, sampled at the rising edge.
- Offset: off = req_addr[log2(XLEN/8)-1:0]. Byte count: bytes = 1<<req_size.
- Misaligned store (off not a multiple of bytes), or size 3 with XLEN=32:
  - The store is consumed, not enqueued.
  - err is pulsed the following cycle.
- Mask: mask = ((1<<bytes)-1) << off.
- Data: data = (req_data & low 8*bytes bits) << (8*off). All other bits are zero.
- Entry contents: {aligned addr, data, mask, mmio}, where mmio = (req_addr[31:28]==MMIO_TAG).
- req_ready = !full && !mmio_pending && !(req_is_mmio && !empty), where mmio_pending means an MMIO entry is in the queue.
  - An MMIO store enters only into an empty queue.
  - Nothing enters behind an MMIO store until it drains.
- req_ready has no combinational dependence on mem_ready.
- Drain: mem_valid = !empty. Head fields come straight from the entry at the read pointer. The head pops on mem_valid && mem_ready.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. count distinguishes full from empty.
- chk_hit = OR over valid entries of (entry.addr == aligned chk_addr && (entry.mask & chk_mask) != 0).
  - chk_mask is computed like mask, even when the load is misaligned.
  - A store accepted in the current cycle is not included; it is visible from the next cycle.
  - The head being popped in the current cycle is still included.

## Timing
- Reset values:
  - Pointers 0, count 0, empty 1.
  - mem_valid 0, mem_mmio 0, err 0, chk_hit 0.
  - Entry contents are don't-care.
- Latency: a store accepted at edge N gives mem_valid=1 in cycle N+1 (queue previously empty). There is no same-cycle bypass.
- mem_addr, mem_data, mem_mask and mem_mmio must hold stable while mem_valid && !mem_ready.
- Throughput: one push and one pop per cycle are sustained when not full and not MMIO.
- Full: req_ready=0 for the whole cycle, even if a pop occurs. The freed slot is usable the next cycle.
- err asserts exactly one cycle after the offending accept. Back-to-back bad stores give back-to-back pulses.
- rst mid-drain: all entries are discarded at that edge. mem_valid=0 from the next cycle and no further beats are issued.

## Test plan
- XLEN=64: push sb addr 0x80000005 data 0xAB.
  - Cycle N+1: mem_addr 0x80000000, mem_mask 8'b00100000, mem_data 0x0000AB0000000000.
- Fill DEPTH=4 with mem_ready=0.
  - count=4, req_ready=0.
  - Raise mem_ready for one cycle: count stays 4 that cycle, req_ready=1 next cycle, order preserved FIFO.
- MMIO: queue holds 2 normal stores, then present sd to 0xA0000000.
  - req_ready=0 until empty, then the store is accepted.
  - mem_mmio=1 on the head.
  - A following normal store stalls until the MMIO store pops.
- Misaligned sw at 0x80000002: no enqueue, count stays 0, err=1 for exactly one cycle.
- Pending sh at 0x80000010 (mask 8'b00000011).
  - chk lb at 0x80000011 gives chk_hit=1.
  - chk lb at 0x80000012 gives chk_hit=0.
- Assert rst with 3 entries while mem_valid=1 and mem_ready=0.
  - Next cycle: count 0, empty 1, mem_valid 0.
  - After reset: a new push drains correctly.
